// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 key-search datapath.
//   MSG_LEN_DEFAULT : default encrypted message length in bytes
//   S_AW            : S memory address width (256-entry permutation)
//   MSG_AW          : message ROM / decrypted RAM address width
//   CNT_W           : character counter width (holds MSG_LEN itself)
//   rc4_state_e     : PRGA loop state encoding
// ---------------------------------------------------------------------------
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;
    localparam int S_AW            = 8;
    localparam int MSG_AW          = 5;
    localparam int CNT_W           = MSG_AW + 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INC_I,
        ST_WAIT_SI,
        ST_READ_SI,
        ST_WAIT_SJ,
        ST_READ_SJ,
        ST_SWAP_J,
        ST_ADDR_F,
        ST_WAIT_F,
        ST_OUT_CHAR,
        ST_WAIT_ACK,
        ST_NEXT_K,
        ST_DONE
    } rc4_state_e;

endpackage

// File: rtl/rc4_decrypt_prga_if.sv
// ---------------------------------------------------------------------------
// rc4_decrypt_prga_if
// Memory and checker-side signals of the PRGA / decryption loop.
//   S memory     : s_addr, s_wdata, s_wren (to RAM), s_rdata (from RAM)
//   message ROM  : rom_addr (to ROM), rom_rdata (from ROM)
//   decrypted RAM: d_addr, d_wdata, d_wren (to RAM)
//   checker      : new_char, char_out, char_count, done (to checker),
//                  compared_char (from checker)
// Modports: master = PRGA block, slave = memories / checker side.
//
// Checker handshake: new_char is a one-cycle valid pulse; char_out is
// stable from that pulse until the next one. compared_char acts as ready /
// acknowledge and is only looked at while the loop waits for it (after the
// new_char pulse has been issued); an earlier acknowledge is dropped.
// ---------------------------------------------------------------------------
interface rc4_decrypt_prga_if;
    import rc4_pkg::*;

    logic [S_AW-1:0]   s_addr;
    logic [7:0]        s_wdata;
    logic              s_wren;
    logic [7:0]        s_rdata;

    logic [MSG_AW-1:0] rom_addr;
    logic [7:0]        rom_rdata;

    logic [MSG_AW-1:0] d_addr;
    logic [7:0]        d_wdata;
    logic              d_wren;

    logic              new_char;
    logic [7:0]        char_out;
    logic              compared_char;
    logic [CNT_W-1:0]  char_count;
    logic              done;

    modport master (
        output s_addr, s_wdata, s_wren,
        input  s_rdata,
        output rom_addr,
        input  rom_rdata,
        output d_addr, d_wdata, d_wren,
        output new_char, char_out, char_count, done,
        input  compared_char
    );

    modport slave (
        input  s_addr, s_wdata, s_wren,
        output s_rdata,
        input  rom_addr,
        output rom_rdata,
        input  d_addr, d_wdata, d_wren,
        input  new_char, char_out, char_count, done,
        output compared_char
    );

endinterface

// File: rtl/rc4_decrypt_prga.sv
// ---------------------------------------------------------------------------
// rc4_decrypt_prga
// RC4 keystream generation + decryption loop. For each message byte k it
// steps i/j through S, swaps s[i]/s[j], reads s[si+sj] as keystream, XORs
// it with ciphertext byte k, writes the plaintext to the decrypted RAM and
// offers it to the character checker.
//
// Ports:
//   clk        : system clock, rising edge
//   resetm     : asynchronous active-low reset
//   start      : begin decryption (sampled in IDLE only)
//   start_over : synchronous abort to IDLE, highest priority
//   bus        : rc4_decrypt_prga_if.master (S memory, ROM, decrypted RAM,
//                checker handshake)
//   state_dbg  : current FSM state, for observation only
//
// Parameter MSG_LEN: message length in bytes (1..32).
//
// Build option RC4_ACK_WAIT_EN: when defined, WAIT_ACK holds until the
// checker returns compared_char. When undefined, WAIT_ACK lasts one cycle
// and compared_char is ignored (standalone decryption).
//
// Memory timing: S RAM and ROM answer on the second clock edge after the
// address register is loaded, hence a WAIT state between every address
// state and the state that consumes the data.
// ---------------------------------------------------------------------------
module rc4_decrypt_prga
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT
)
(
    input  logic                      clk,
    input  logic                      resetm,
    input  logic                      start,
    input  logic                      start_over,
    rc4_decrypt_prga_if.master        bus,
    output rc4_state_e                state_dbg
);

    rc4_state_e state, state_n;

    logic [7:0]        i, j, si, sj;
    logic [CNT_W-1:0]  k, k_inc;

    logic [S_AW-1:0]   s_addr_q;
    logic [7:0]        s_wdata_q;
    logic              s_wren_q;
    logic [MSG_AW-1:0] rom_addr_q;
    logic [MSG_AW-1:0] d_addr_q;
    logic [7:0]        d_wdata_q;
    logic              d_wren_q;
    logic              new_char_q;
    logic [7:0]        char_out_q;
    logic [7:0]        plain;
    logic              done_c;

    assign k_inc = k + 1'b1;
    assign plain = bus.s_rdata ^ bus.rom_rdata;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetm) begin
        if (!resetm) state <= ST_IDLE;
        else         state <= state_n;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_n = state;
        if (start_over) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (start) state_n = ST_INC_I;
                ST_INC_I:    state_n = ST_WAIT_SI;
                ST_WAIT_SI:  state_n = ST_READ_SI;
                ST_READ_SI:  state_n = ST_WAIT_SJ;
                ST_WAIT_SJ:  state_n = ST_READ_SJ;
                ST_READ_SJ:  state_n = ST_SWAP_J;
                ST_SWAP_J:   state_n = ST_ADDR_F;
                ST_ADDR_F:   state_n = ST_WAIT_F;
                ST_WAIT_F:   state_n = ST_OUT_CHAR;
                ST_OUT_CHAR: state_n = ST_WAIT_ACK;
`ifdef RC4_ACK_WAIT_EN
                ST_WAIT_ACK: if (bus.compared_char) state_n = ST_NEXT_K;
`else
                ST_WAIT_ACK: state_n = ST_NEXT_K;
`endif
                ST_NEXT_K:   state_n = (k_inc == CNT_W'(MSG_LEN)) ? ST_DONE : ST_INC_I;
                ST_DONE:     state_n = ST_DONE;
                default:     state_n = ST_IDLE;
            endcase
        end
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        done_c    = (state == ST_DONE);
        state_dbg = state;
    end

`ifndef RC4_ACK_WAIT_EN
    // Free-running build: the acknowledge is intentionally not consumed.
    logic ack_unused;
    assign ack_unused = bus.compared_char;
`endif

    // ---------------- datapath registers ----------------
    // start_over clears the loop indices and all strobes but leaves
    // char_out, si/sj and the address registers as they were.
    always_ff @(posedge clk or negedge resetm) begin
        if (!resetm) begin
            i          <= '0;
            j          <= '0;
            si         <= '0;
            sj         <= '0;
            k          <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wren_q   <= 1'b0;
            rom_addr_q <= '0;
            d_addr_q   <= '0;
            d_wdata_q  <= '0;
            d_wren_q   <= 1'b0;
            new_char_q <= 1'b0;
            char_out_q <= '0;
        end else if (start_over) begin
            i          <= '0;
            j          <= '0;
            k          <= '0;
            s_wren_q   <= 1'b0;
            d_wren_q   <= 1'b0;
            new_char_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                ST_INC_I: begin
                    i        <= i + 8'd1;
                    s_addr_q <= i + 8'd1;
                end
                ST_READ_SI: begin
                    si       <= bus.s_rdata;
                    j        <= j + bus.s_rdata;
                    s_addr_q <= j + bus.s_rdata;
                end
                ST_READ_SJ: begin
                    // First half of the swap: s[i] <= s[j].
                    sj        <= bus.s_rdata;
                    s_addr_q  <= i;
                    s_wdata_q <= bus.s_rdata;
                    s_wren_q  <= 1'b1;
                end
                ST_SWAP_J: begin
                    // Second half of the swap: s[j] <= old s[i].
                    s_addr_q  <= j;
                    s_wdata_q <= si;
                    s_wren_q  <= 1'b1;
                end
                ST_ADDR_F: begin
                    s_wren_q   <= 1'b0;
                    s_addr_q   <= si + sj;
                    rom_addr_q <= k[MSG_AW-1:0];
                end
                ST_OUT_CHAR: begin
                    char_out_q <= plain;
                    d_addr_q   <= k[MSG_AW-1:0];
                    d_wdata_q  <= plain;
                    d_wren_q   <= 1'b1;
                    new_char_q <= 1'b1;
                end
                ST_WAIT_ACK: begin
                    new_char_q <= 1'b0;
                    d_wren_q   <= 1'b0;
                end
                ST_NEXT_K: begin
                    k <= k_inc;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_addr     = s_addr_q;
    assign bus.s_wdata    = s_wdata_q;
    assign bus.s_wren     = s_wren_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.d_addr     = d_addr_q;
    assign bus.d_wdata    = d_wdata_q;
    assign bus.d_wren     = d_wren_q;
    assign bus.new_char   = new_char_q;
    assign bus.char_out   = char_out_q;
    assign bus.char_count = k;
    assign bus.done       = done_c;

endmodule

// File: tb/tb_rc4_decrypt_prga.sv
// ---------------------------------------------------------------------------
// tb_rc4_decrypt_prga
// Bench for rc4_decrypt_prga. Provides a synchronous S RAM and message ROM
// model, a reference RC4 keystream model that fills the expected queue, and
// a second MSG_LEN=1 instance for the single-character case. Works in both
// builds (RC4_ACK_WAIT_EN defined or not).
// ---------------------------------------------------------------------------
module tb_rc4_decrypt_prga;
    import rc4_pkg::*;

    localparam int N = MSG_LEN_DEFAULT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetm;
    logic start, start_over;
    logic start1, start_over1;
    rc4_state_e state_dbg, state_dbg1;

    always #5 clk = ~clk;

    rc4_decrypt_prga_if bus();
    rc4_decrypt_prga_if bus1();

    rc4_decrypt_prga #(.MSG_LEN(N)) dut (
        .clk(clk), .resetm(resetm), .start(start), .start_over(start_over),
        .bus(bus), .state_dbg(state_dbg)
    );

    rc4_decrypt_prga #(.MSG_LEN(1)) dut1 (
        .clk(clk), .resetm(resetm), .start(start1), .start_over(start_over1),
        .bus(bus1), .state_dbg(state_dbg1)
    );

    // Single-character instance: all-zero memories, acknowledges at once.
    assign bus1.s_rdata       = 8'h00;
    assign bus1.rom_rdata     = 8'h00;
    assign bus1.compared_char = bus1.new_char;

    // ---------------- memory models ----------------
    logic [7:0] s_mem   [256];
    logic [7:0] rom_mem [N];
    logic       s_init_req = 1'b0;

    always @(posedge clk) begin
        if (s_init_req) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= 8'(a);
        end else if (bus.s_wren) begin
            s_mem[bus.s_addr] <= bus.s_wdata;
        end
        bus.s_rdata   <= s_mem[bus.s_addr];
        bus.rom_rdata <= rom_mem[bus.rom_addr];
    end

    // ---------------- counters ----------------
    int cyc = 0;
    int nc_count = 0;
    int nc1_count = 0;
    logic nc_clr = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (nc_clr) nc_count <= 0;
        else if (bus.new_char === 1'b1) nc_count <= nc_count + 1;
        if (bus1.new_char === 1'b1) nc1_count <= nc1_count + 1;
    end

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];   // {d_addr, char}
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference RC4 PRGA from an identity S; pushes the first n plaintexts.
    task automatic build_expected(input int n);
        logic [7:0] sm [256];
        logic [7:0] ri, rj, t, f;
        for (int a = 0; a < 256; a++) sm[a] = 8'(a);
        ri = 8'd0;
        rj = 8'd0;
        for (int kk = 0; kk < n; kk++) begin
            ri     = ri + 8'd1;
            rj     = rj + sm[ri];
            t      = sm[ri];
            sm[ri] = sm[rj];
            sm[rj] = t;
            f      = sm[ri] + sm[rj];
            exp_q.push_back({5'(kk), sm[f] ^ rom_mem[kk]});
        end
    endtask

    task automatic init_s();
        @(negedge clk) s_init_req = 1'b1;
        @(negedge clk) s_init_req = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetm = 1'b0;
        start = 1'b0; start_over = 1'b0;
        start1 = 1'b0; start_over1 = 1'b0;
        bus.compared_char = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state_dbg !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE);
        end
        n_cmp++;
        if ({bus.s_addr, bus.s_wdata, bus.s_wren} !== 17'd0) begin
            n_fail++; $display("FAIL reset_s_port: got %h/%h/%b want 0", bus.s_addr, bus.s_wdata, bus.s_wren);
        end
        n_cmp++;
        if ({bus.new_char, bus.char_out, bus.rom_addr} !== 14'd0) begin
            n_fail++; $display("FAIL reset_char: got nc=%b char=%h rom=%h want 0", bus.new_char, bus.char_out, bus.rom_addr);
        end
        n_cmp++;
        if ({bus.d_addr, bus.d_wdata, bus.d_wren} !== 14'd0) begin
            n_fail++; $display("FAIL reset_d_port: got %h/%h/%b want 0", bus.d_addr, bus.d_wdata, bus.d_wren);
        end
        n_cmp++;
        if ({bus.done, bus.char_count} !== 7'd0) begin
            n_fail++; $display("FAIL reset_done_count: got done=%b count=%0d want 0/0", bus.done, bus.char_count);
        end
        @(negedge clk) resetm = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_collision();
        @(negedge clk) begin start = 1'b1; start_over = 1'b1; end
        @(negedge clk) begin start = 1'b0; start_over = 1'b0; end
        n_cmp++;
        if (state_dbg !== ST_IDLE || bus.s_addr !== 8'd0) begin
            n_fail++; $display("FAIL collision_idle: got state=%0d s_addr=%h want IDLE/00", state_dbg, bus.s_addr);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state_dbg !== ST_IDLE || bus.s_wren !== 1'b0 || bus.new_char !== 1'b0) begin
            n_fail++; $display("FAIL collision_hold: got state=%0d s_wren=%b nc=%b want IDLE/0/0", state_dbg, bus.s_wren, bus.new_char);
        end
    endtask

    task automatic test_full_message();
        logic        got;
        logic [12:0] exp;
        int          last;
        rom_mem[0] = 8'h63;
        rom_mem[1] = 8'h67;
        for (int a = 2; a < N; a++) rom_mem[a] = 8'($urandom_range(0, 255));
        exp_q.delete();
        build_expected(N);
        init_s();
        @(negedge clk) nc_clr = 1'b1;
        @(negedge clk) nc_clr = 1'b0;
        pulse_start();
        last = 0;
        for (int k = 0; k < N; k++) begin
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (bus.new_char === 1'b1) begin got = 1'b1; break; end
            end
            n_cmp++;
            if (!got) begin
                n_fail++; $display("FAIL msg_char%0d_timeout: no new_char, want one within 40 cycles", k);
                return;
            end
            exp = exp_q.pop_front();
            n_cmp++;
            if ({bus.d_addr, bus.char_out} !== exp) begin
                n_fail++; $display("FAIL msg_char%0d: got addr=%0d char=%h want addr=%0d char=%h", k, bus.d_addr, bus.char_out, exp[12:8], exp[7:0]);
            end
            n_cmp++;
            if (bus.d_wdata !== exp[7:0] || bus.d_wren !== 1'b1) begin
                n_fail++; $display("FAIL msg_dwrite%0d: got wdata=%h wren=%b want %h/1", k, bus.d_wdata, bus.d_wren, exp[7:0]);
            end
            if (k == 0) begin
                n_cmp++;
                if (s_mem[1] !== 8'd1 || s_mem[2] !== 8'd2) begin
                    n_fail++; $display("FAIL s_after_char0: got s[1]=%h s[2]=%h want 01/02", s_mem[1], s_mem[2]);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (s_mem[2] !== 8'd3 || s_mem[3] !== 8'd2) begin
                    n_fail++; $display("FAIL swap_char1: got s[2]=%h s[3]=%h want 03/02", s_mem[2], s_mem[3]);
                end
            end
`ifdef RC4_ACK_WAIT_EN
            if (k < 2) begin
                for (int w = 0; w < 3; w++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (bus.char_count !== 6'(k) || {bus.new_char, bus.d_wren} !== 2'b00) begin
                        n_fail++; $display("FAIL hold_before_ack%0d: got count=%0d nc=%b wren=%b want %0d/0/0", k, bus.char_count, bus.new_char, bus.d_wren, k);
                    end
                end
                bus.compared_char = 1'b1;
                @(negedge clk) bus.compared_char = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (bus.char_count !== 6'(k + 1)) begin
                    n_fail++; $display("FAIL k_after_ack%0d: got %0d want %0d", k, bus.char_count, k + 1);
                end
            end else begin
                @(negedge clk) bus.compared_char = 1'b1;
                @(negedge clk) bus.compared_char = 1'b0;
            end
`else
            if (k > 0) begin
                n_cmp++;
                if (cyc - last !== 11) begin
                    n_fail++; $display("FAIL char_period%0d: got %0d cycles want 11", k, cyc - last);
                end
            end
            last = cyc;
`endif
        end
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin got = 1'b1; break; end
        end
        n_cmp++;
        if (!got || bus.char_count !== 6'(N) || state_dbg !== ST_DONE) begin
            n_fail++; $display("FAIL msg_done: got done=%b count=%0d state=%0d want 1/%0d/DONE", bus.done, bus.char_count, state_dbg, N);
        end
        n_cmp++;
        if (nc_count !== N || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL msg_pulses: got %0d pulses, %0d left want %0d/0", nc_count, exp_q.size(), N);
        end
    endtask

    task automatic test_done_hold();
        for (int p = 0; p < 3; p++) begin
            pulse_start();
            @(negedge clk);
            n_cmp++;
            if (bus.done !== 1'b1 || bus.char_count !== 6'(N)) begin
                n_fail++; $display("FAIL done_hold%0d: got done=%b count=%0d want 1/%0d", p, bus.done, bus.char_count, N);
            end
        end
        n_cmp++;
        if (nc_count !== N) begin
            n_fail++; $display("FAIL done_no_char: got %0d pulses want %0d", nc_count, N);
        end
    endtask

    task automatic test_start_over();
        logic        got;
        logic [12:0] exp;
        int          snap;
        @(negedge clk) start_over = 1'b1;
        @(negedge clk) start_over = 1'b0;
        n_cmp++;
        if (state_dbg !== ST_IDLE || bus.done !== 1'b0 || bus.char_count !== 6'd0) begin
            n_fail++; $display("FAIL abort_done: got state=%0d done=%b count=%0d want IDLE/0/0", state_dbg, bus.done, bus.char_count);
        end
        // Two passes: the first is aborted in WAIT_F of the third character,
        // the second checks that a fresh start begins again at k=0.
        for (int pass = 0; pass < 2; pass++) begin
            exp_q.delete();
            build_expected(2);
            init_s();
            pulse_start();
            for (int k = 0; k < 2; k++) begin
                got = 1'b0;
                for (int t = 0; t < 40; t++) begin
                    @(negedge clk);
                    if (bus.new_char === 1'b1) begin got = 1'b1; break; end
                end
                n_cmp++;
                if (!got) begin
                    n_fail++; $display("FAIL so_char%0d_timeout: pass %0d no new_char within 40 cycles", k, pass);
                    return;
                end
                exp = exp_q.pop_front();
                n_cmp++;
                if ({bus.d_addr, bus.char_out} !== exp) begin
                    n_fail++; $display("FAIL so_char%0d: pass %0d got addr=%0d char=%h want addr=%0d char=%h", k, pass, bus.d_addr, bus.char_out, exp[12:8], exp[7:0]);
                end
                if (pass == 0) begin
`ifdef RC4_ACK_WAIT_EN
                    @(negedge clk) bus.compared_char = 1'b1;
                    @(negedge clk) bus.compared_char = 1'b0;
`endif
                end
            end
            if (pass == 0) begin
                got = 1'b0;
                for (int t = 0; t < 20; t++) begin
                    if (state_dbg === ST_WAIT_F) begin got = 1'b1; break; end
                    @(negedge clk);
                end
                n_cmp++;
                if (!got) begin
                    n_fail++; $display("FAIL so_reach_wait_f: state=%0d, want WAIT_F within 20 cycles", state_dbg);
                    return;
                end
                start_over = 1'b1;
                @(negedge clk) start_over = 1'b0;
                n_cmp++;
                if (state_dbg !== ST_IDLE || bus.char_count !== 6'd0 || bus.new_char !== 1'b0 ||
                    bus.s_wren !== 1'b0 || bus.d_wren !== 1'b0) begin
                    n_fail++; $display("FAIL so_abort: got state=%0d count=%0d nc=%b s_wren=%b d_wren=%b want IDLE/0/0/0/0",
                                       state_dbg, bus.char_count, bus.new_char, bus.s_wren, bus.d_wren);
                end
                snap = nc_count;
                repeat (15) @(negedge clk);
                n_cmp++;
                if (nc_count !== snap || state_dbg !== ST_IDLE) begin
                    n_fail++; $display("FAIL so_quiet: got %0d extra pulses state=%0d want 0/IDLE", nc_count - snap, state_dbg);
                end
            end else begin
                start_over = 1'b1;
                @(negedge clk) start_over = 1'b0;
            end
        end
    endtask

    task automatic test_msg_len_one();
        logic got;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) begin got = 1'b1; break; end
        end
        n_cmp++;
        if (!got || bus1.char_count !== 6'd1 || state_dbg1 !== ST_DONE) begin
            n_fail++; $display("FAIL len1_done: got done=%b count=%0d state=%0d want 1/1/DONE", bus1.done, bus1.char_count, state_dbg1);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (nc1_count !== 1 || bus1.char_out !== 8'h00) begin
            n_fail++; $display("FAIL len1_chars: got %0d pulses char=%h want 1/00", nc1_count, bus1.char_out);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        test_reset();
        test_start_collision();
        test_full_message();
        test_done_hold();
        test_start_over();
        test_msg_len_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1);
    end

endmodule

// File: doc/rc4_decrypt_prga.md
# rc4_decrypt_prga

RC4 keystream-generation and decryption loop (PRGA) for the key-search datapath. After S-box init and key scheduling complete, it walks the encrypted message ROM. For each byte it derives one keystream byte from S memory, XORs it with the ciphertext, writes the result to decrypted RAM, and offers the character to the character checker over a new_char / compared_char handshake. The checker's start_over aborts the walk so the next key can be tried.

## Interface
- MSG_LEN, 32: message length in bytes; k runs 0..MSG_LEN-1.
- clk  in  1  system clock, rising edge.
- resetm  in  1  reset, asynchronous, active-low.
- start  in  1  begin decryption; sampled only in IDLE.
- start_over  in  1  abort to IDLE from any state, synchronous.
- compared_char  in  1  checker finished the current character.
- s_addr  out  8  S memory address, registered.
- s_wdata  out  8  S memory write data, registered.
- s_wren  out  1  S memory write enable, registered.
- s_rdata  in  8  S memory read data; synchronous RAM, valid 2 edges after s_addr is registered.
- rom_addr  out  5  encrypted ROM address, equals k.
- rom_rdata  in  8  ciphertext byte; same latency as s_rdata.
- d_addr  out  5  decrypted RAM address.
- d_wdata  out  8  decrypted byte.
- d_wren  out  1  decrypted RAM write enable, one-cycle pulse.
- new_char  out  1  one-cycle pulse; char_out is valid.
- char_out  out  8  decrypted character, held until the next new_char.
- char_count  out  6  current k; equals MSG_LEN once finished.
- done  out  1  high in DONE until start_over or reset.

## Operation
- Registers: i, j, si, sj (8 bit each, wrap mod 256); k (6 bit).
- States and transitions:
  - IDLE: on start, clear i, j, k and go to INC_I.
  - INC_I: i <= i+1; s_addr <= i+1.
  - WAIT_SI: no register updates.
  - READ_SI: si <= s_rdata; j <= j+s_rdata; s_addr <= j+s_rdata.
  - WAIT_SJ: no register updates.
  - READ_SJ: sj <= s_rdata; write s[i] <= s_rdata (s_addr=i, s_wren=1).
  - SWAP_J: write s[j] <= si.
  - ADDR_F: s_wren <= 0; s_addr <= si+sj (8-bit wrap); rom_addr <= k.
  - WAIT_F: no register updates.
  - OUT_CHAR: char_out <= s_rdata ^ rom_rdata; d_addr <= k; d_wdata <= same value; d_wren <= 1; new_char <= 1.
  - WAIT_ACK: new_char and d_wren return to 0.
  - NEXT_K: k <= k+1; go to DONE if k+1 == MSG_LEN, else to INC_I.
  - DONE: done=1; hold.
- compared_char is sampled only in WAIT_ACK. An ack arriving earlier is ignored.
- start_over has priority over every other condition, including start in the same cycle. It forces IDLE and clears i, j, k, new_char, s_wren, d_wren and done. char_out keeps its value.
- start_over during READ_SJ or SWAP_J may leave S half-swapped. This is acceptable because the next key re-initialises S.
- Reset values: all outputs 0, state IDLE, i = j = k = si = sj = 0.

## Timing
- s_rdata is sampled exactly 2 cycles after the state that registers s_addr.
- Without ack stall, each character takes 11 cycles from INC_I to NEXT_K.
- new_char is high for exactly one cycle, in the cycle after OUT_CHAR. d_wren is high in that same cycle.
- char_count updates one cycle after NEXT_K. The checker sees char_count == MSG_LEN when done rises.
- For MSG_LEN=1, DONE is reached after a single character.

## Configuration
- RC4_ACK_WAIT_EN defined: WAIT_ACK holds until compared_char=1, then goes to NEXT_K.
- RC4_ACK_WAIT_EN undefined: WAIT_ACK lasts exactly one cycle and compared_char is ignored. This free-running mode is for standalone decryption.

## Structure
- Shared package rc4_pkg holds:
  - the state enum type;
  - MSG_LEN_DEFAULT (32);
  - constants for the S address width (8) and message address width (5).
- No sub-module is needed. The S-memory port multiplexer shared with the init and KSA loops lives outside this block.

## Test plan
- S = identity, enc[0]=0x63, start pulse, RC4_ACK_WAIT_EN defined, ack 3 cycles after new_char:
  - response: char_out=0x61, d_addr=0, d_wdata=0x61;
  - S unchanged (i = j = 1);
  - k advances to 1 only after the ack.
- Continue with enc[1]=0x67:
  - i=2, j=3; the swap writes s[2]=3, s[3]=2;
  - f=s[5]=5; char_out=0x62.
- MSG_LEN=32, ack returned 1 cycle after each new_char:
  - exactly 32 new_char pulses;
  - done=1 with char_count=32;
  - done stays high under further start pulses.
- start_over asserted in WAIT_F of the third character:
  - next cycle: IDLE, char_count=0, no new_char, s_wren=0;
  - a subsequent start restarts decryption at k=0.
- start and start_over asserted in the same cycle in IDLE: the block remains in IDLE and s_addr is unchanged.
- RC4_ACK_WAIT_EN undefined, compared_char tied 0: decryption completes all MSG_LEN characters at 11 cycles per character.
